// File: rtl/demosaic_window_ctrl.sv
// rtl/demosaic_window_ctrl.sv - window sequencing controller for the 7x7 Bayer demosaic datapath
module demosaic_window_ctrl #(
    parameter int IMG_W     = 1920,
    parameter int IMG_H     = 1080,
    parameter int BAYER_PAT = 0,
    parameter int PIPE_LAT  = 2,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          in_ready,
    output logic          win_shift,
    output logic [CW-1:0] lb_addr,
    output logic          out_valid,
    output logic [1:0]    out_phase,
    output logic          out_border,
    output logic [CW-1:0] out_col,
    output logic [CW-1:0] out_row,
    output logic          frame_done,
    output logic          frame_err
);
    localparam int LW = CW + 2;
    localparam int PW = 2 * CW + 4;
    localparam logic [LW-1:0] LAG      = LW'(3 * IMG_W + 3);
    localparam logic [LW-1:0] LAG_M1   = LW'(3 * IMG_W + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_HI   = CW'(IMG_W - 4);
    localparam logic [CW-1:0] ROW_HI   = CW'(IMG_H - 4);
    localparam logic [CW-1:0] EDGE     = CW'(3);
    localparam logic [1:0]    PAT      = 2'(BAYER_PAT);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] in_col, in_row, ctr_col, ctr_row;
    logic [LW-1:0] lag_cnt;
    logic          sof_tick, tick, issue, last_pix, lag_hit, flush_end, border;
    logic [PW-1:0] ctr_word;
    logic [PW-1:0] pipe [0:PIPE_LAT];

    assign last_pix  = (in_col == COL_LAST) && (in_row == ROW_LAST);
    assign lag_hit   = (lag_cnt == LAG);
    assign flush_end = (lag_cnt == LAG_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sof_tick) state_nxt = FILL;
            FILL:    if (sof_tick) state_nxt = FILL;
                     else if (tick && lag_hit) state_nxt = RUN;
            RUN:     if (sof_tick) state_nxt = FILL;
                     else if (tick && last_pix) state_nxt = FLUSH;
            default: if (flush_end) state_nxt = IDLE;
        endcase
    end

    // A sof pixel always restarts at column 0, even when it aborts a frame.
    always_comb begin
        in_ready = (state != FLUSH);
        sof_tick = 1'b0;
        tick     = 1'b0;
        issue    = 1'b0;
        case (state)
            IDLE: begin
                sof_tick = in_valid & in_sof;
                tick     = sof_tick;
            end
            FILL, RUN: begin
                sof_tick = in_valid & in_sof;
                tick     = in_valid;
                issue    = in_valid & ~in_sof & ((state == RUN) | lag_hit);
            end
            default: begin
                tick  = 1'b1;
                issue = 1'b1;
            end
        endcase
        lb_addr   = sof_tick ? '0 : in_col;
        win_shift = tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col  <= '0;
            in_row  <= '0;
            ctr_col <= '0;
            ctr_row <= '0;
            lag_cnt <= '0;
        end else if (sof_tick) begin
            in_col  <= CW'(1);
            in_row  <= '0;
            ctr_col <= '0;
            ctr_row <= '0;
            lag_cnt <= LW'(1);
        end else begin
            if (state == FLUSH && flush_end) begin
                in_col <= '0;
                in_row <= '0;
            end else if (tick) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + CW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end
            if (issue) begin
                if (ctr_col == COL_LAST) begin
                    ctr_col <= '0;
                    ctr_row <= (ctr_row == ROW_LAST) ? '0 : ctr_row + CW'(1);
                end else begin
                    ctr_col <= ctr_col + CW'(1);
                end
            end
            // lag_cnt counts fill ticks up to LAG, then flush cycles up to LAG-1.
            case (state)
                FILL:    if (tick) lag_cnt <= lag_hit ? '0 : lag_cnt + LW'(1);
                FLUSH:   lag_cnt <= flush_end ? '0 : lag_cnt + LW'(1);
                default: lag_cnt <= '0;
            endcase
        end
    end

    assign border   = (ctr_row < EDGE) || (ctr_row > ROW_HI) || (ctr_col < EDGE) || (ctr_col > COL_HI);
    assign ctr_word = issue ? {1'b1, ctr_row[0] ^ PAT[1], ctr_col[0] ^ PAT[0], border, ctr_col, ctr_row}
                            : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIPE_LAT; i++) pipe[i] <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pipe[0] <= ctr_word;
            for (int i = 1; i <= PIPE_LAT; i++) pipe[i] <= pipe[i-1];
            frame_done <= (state == FLUSH) && flush_end;
            frame_err  <= sof_tick && ((state == FILL) || (state == RUN));
        end
    end

    assign {out_valid, out_phase, out_border, out_col, out_row} = pipe[PIPE_LAT];
endmodule

// File: tb/tb_demosaic_window_ctrl.sv
// tb/tb_demosaic_window_ctrl.sv - randomized self-checking bench for demosaic_window_ctrl
module tb_demosaic_window_ctrl;
    localparam int W = 8, H = 7, N = W * H, LAG = 3 * W + 3, PL = 2, CW = 11, MAXC = 4096;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
    logic          rdy0, ws0, ov0, b0, dn0, er0;
    logic          rdy1, ws1, ov1, b1, dn1, er1;
    logic          rdy3, ws3, ov3, b3, dn3, er3;
    logic [CW-1:0] lb0, col0, row0, lb1, col1, row1, lb3, col3, row3;
    logic [1:0]    ph0, ph1, ph3;

    demosaic_window_ctrl #(.IMG_W(W), .IMG_H(H), .BAYER_PAT(0), .PIPE_LAT(PL), .CW(CW)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_ready(rdy0),
        .win_shift(ws0), .lb_addr(lb0), .out_valid(ov0), .out_phase(ph0), .out_border(b0),
        .out_col(col0), .out_row(row0), .frame_done(dn0), .frame_err(er0));
    demosaic_window_ctrl #(.IMG_W(W), .IMG_H(H), .BAYER_PAT(1), .PIPE_LAT(PL), .CW(CW)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_ready(rdy1),
        .win_shift(ws1), .lb_addr(lb1), .out_valid(ov1), .out_phase(ph1), .out_border(b1),
        .out_col(col1), .out_row(row1), .frame_done(dn1), .frame_err(er1));
    demosaic_window_ctrl #(.IMG_W(W), .IMG_H(H), .BAYER_PAT(3), .PIPE_LAT(PL), .CW(CW)) d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_ready(rdy3),
        .win_shift(ws3), .lb_addr(lb3), .out_valid(ov3), .out_phase(ph3), .out_border(b3),
        .out_col(col3), .out_row(row3), .frame_done(dn3), .frame_err(er3));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, k = 0, npix = 0, last_due = 0;
    bit active = 0;
    bit e_ov [MAXC];
    bit e_done [MAXC];
    bit e_err [MAXC];
    int e_col [MAXC];
    int e_row [MAXC];
    int n_ws, n_nrdy, n_done, n_err, n_ov, n_b0, first_ov, sof_cyc;
    logic [1:0] ph_tbl [0:3][0:3] = '{'{2'd0, 2'd1, 2'd2, 2'd3}, '{2'd1, 2'd0, 2'd3, 2'd2},
                                      '{2'd2, 2'd3, 2'd0, 2'd1}, '{2'd3, 2'd2, 2'd1, 2'd0}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit border_of(input int r, input int c);
        return (r < 3) || (r >= H - 3) || (c < 3) || (c >= W - 3);
    endfunction

    task automatic check_dut(input int pat, input logic rdy_o, ws_o, input logic [CW-1:0] lb_o,
                             input logic ov_o, input logic [1:0] ph_o, input logic b_o,
                             input logic [CW-1:0] col_o, row_o, input logic done_o, err_o,
                             input bit rdy, tk, input int lbx);
        chk($sformatf("in_ready/p%0d@%0d", pat, cyc), rdy_o, rdy);
        chk($sformatf("win_shift/p%0d@%0d", pat, cyc), ws_o, tk);
        if (tk) chk($sformatf("lb_addr/p%0d@%0d", pat, cyc), lb_o, lbx);
        chk($sformatf("out_valid/p%0d@%0d", pat, cyc), ov_o, e_ov[cyc]);
        if (e_ov[cyc]) begin
            chk($sformatf("phase/p%0d@%0d", pat, cyc), ph_o,
                ph_tbl[pat][2 * (e_row[cyc] % 2) + (e_col[cyc] % 2)]);
            chk($sformatf("border/p%0d@%0d", pat, cyc), b_o, border_of(e_row[cyc], e_col[cyc]));
            chk($sformatf("col/p%0d@%0d", pat, cyc), col_o, e_col[cyc]);
            chk($sformatf("row/p%0d@%0d", pat, cyc), row_o, e_row[cyc]);
        end
        chk($sformatf("frame_done/p%0d@%0d", pat, cyc), done_o, e_done[cyc]);
        chk($sformatf("frame_err/p%0d@%0d", pat, cyc), err_o, e_err[cyc]);
    endtask

    task automatic model_reset();
        active = 0; k = 0; npix = 0;
        for (int i = cyc; i < MAXC; i++) begin
            e_ov[i] = 0; e_done[i] = 0; e_err[i] = 0;
        end
    endtask

    task automatic stats_clear();
        n_ws = 0; n_nrdy = 0; n_done = 0; n_err = 0; n_ov = 0; n_b0 = 0; first_ov = -1;
    endtask

    task automatic run_cycle(input logic v, input logic s, output bit acc);
        bit flushing, rdy, tk;
        int lbx, ctr;
        if (cyc >= MAXC - 8) begin
            $display("FAIL cycle_budget observed=%0d required<%0d", cyc, MAXC - 8);
            $fatal(1);
        end
        in_valid = v; in_sof = s;
        @(negedge clk);
        flushing = active && (npix == N);
        rdy = !flushing;
        acc = v && rdy;
        tk = 0; lbx = 0; ctr = -1;
        if (flushing) begin
            tk = 1; lbx = k % W; ctr = k - LAG; k++;
            if (k == N + LAG) begin
                active = 0; npix = 0; e_done[cyc + 1] = 1;
            end
        end else if (acc && s) begin
            if (active) e_err[cyc + 1] = 1;
            active = 1; tk = 1; lbx = 0; k = 1; npix = 1;
        end else if (acc && active) begin
            tk = 1; lbx = k % W;
            if (k >= LAG) ctr = k - LAG;
            k++; npix++;
        end
        if (ctr >= 0) begin
            e_ov[cyc + PL + 1] = 1; e_row[cyc + PL + 1] = ctr / W; e_col[cyc + PL + 1] = ctr % W;
            last_due = cyc + PL + 1;
        end
        if (cyc + 1 > last_due && (e_done[cyc + 1] || e_err[cyc + 1])) last_due = cyc + 1;
        check_dut(0, rdy0, ws0, lb0, ov0, ph0, b0, col0, row0, dn0, er0, rdy, tk, lbx);
        check_dut(1, rdy1, ws1, lb1, ov1, ph1, b1, col1, row1, dn1, er1, rdy, tk, lbx);
        check_dut(3, rdy3, ws3, lb3, ov3, ph3, b3, col3, row3, dn3, er3, rdy, tk, lbx);
        n_ws += int'(ws0); n_nrdy += int'(!rdy0); n_done += int'(dn0); n_err += int'(er0);
        if (ov0) begin
            n_ov++;
            if (!b0) n_b0++;
            if (first_ov < 0) first_ov = cyc;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic send_pixels(input int n, input int mode, input bit sof_first);
        int sent = 0, budget = 0;
        bit acc, v;
        while (sent < n) begin
            case (mode)
                0:       v = 1;
                1:       v = (budget % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            run_cycle(v, sof_first && (sent == 0), acc);
            if (acc) sent++;
            budget++;
            if (budget > 1000) begin
                chk("send_budget", sent, n);
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        bit acc;
        while ((active || cyc <= last_due) && n < 200) begin
            run_cycle(0, 0, acc);
            n++;
        end
        if (n >= 200) chk("drain_timeout", n, 0);
    endtask

    initial begin
        bit acc;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", rdy0, 1);
        chk("rst_outputs", {ws0, lb0, ov0, ph0, b0, col0, row0, dn0, er0}, 0);
        @(posedge clk); #1;
        rst_n = 1;

        stats_clear();
        sof_cyc = cyc;
        send_pixels(N, 0, 1);
        drain();
        chk("a_win_shift", n_ws, N + LAG);
        chk("a_not_ready", n_nrdy, LAG);
        chk("a_frame_done", n_done, 1);
        chk("a_out_valid", n_ov, N);
        chk("a_first_latency", first_ov - sof_cyc, LAG + PL + 1);
        chk("a_inner_centres", n_b0, 2);

        stats_clear();
        send_pixels(N, 1, 1);
        drain();
        chk("b_out_valid", n_ov, N);
        chk("b_frame_done", n_done, 1);

        stats_clear();
        send_pixels(40, 0, 1);
        send_pixels(N, 0, 1);
        drain();
        chk("r_frame_err", n_err, 1);
        chk("r_frame_done", n_done, 1);
        chk("r_out_valid", n_ov, 13 + N);

        send_pixels(N, 0, 1);
        repeat (5) run_cycle(0, 0, acc);
        rst_n = 0;
        #1;
        chk("flush_rst_in_ready", rdy0, 1);
        chk("flush_rst_outputs", {ws0, lb0, ov0, ph0, b0, col0, row0, dn0, er0}, 0);
        model_reset();
        repeat (2) run_cycle(0, 0, acc);
        rst_n = 1;
        stats_clear();
        repeat (3) run_cycle(1, 0, acc);
        chk("no_sof_dropped", n_ws, 0);

        stats_clear();
        send_pixels(N, 2, 1);
        drain();
        chk("rand_out_valid", n_ov, N);
        chk("rand_frame_done", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
